// File: rtl/lights_game_ctrl.sv
// LED light-chase game sequencer: moves one lit red LED on prescaler ticks,
// scores hits at TARGET, tracks lives/level, drives the red/green display banks.
// Ports: clk, reset (async low), enable, tick, btn_start, btn_hit, modo
//        -> leds_red[7:0], leds_green[7:0], score[3:0], lives[1:0], level[1:0], game_state[2:0]
module lights_game_ctrl #(
  parameter int TARGET      = 4,
  parameter int WIN_SCORE   = 8,
  parameter int LIVES       = 3,
  parameter int FLASH_TICKS = 4,
  parameter int LEVEL_STEP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_hit,
  input  logic       modo,
  output logic [7:0] leds_red,
  output logic [7:0] leds_green,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [2:0] game_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_HIT  = 3'd2,
    S_MISS = 3'd3,
    S_OVER = 3'd4,
    S_WIN  = 3'd5
  } state_e;

  state_e     state, state_n;
  logic [2:0] pos, pos_n;
  logic       dir, dir_n;
  logic [1:0] step_cnt, step_n;
  logic [3:0] flash_cnt, flash_n;
  logic       blink, blink_n;
  logic [3:0] score_n;
  logic [1:0] lives_n, level_n;
  logic [7:0] red_n, green_n;
  logic [2:0] mv_pos;
  logic       mv_dir;

  // dir: 0 = up, 1 = down
  always_comb begin
    mv_pos = pos;
    mv_dir = 1'b0;
    if (modo) begin
      mv_pos = pos + 3'd1;
      mv_dir = 1'b0;
    end else if (!dir) begin
      if (pos == 3'd7) begin
        // reachable only after a wrap->bounce switch at the top end
        mv_pos = 3'd6;
        mv_dir = 1'b1;
      end else begin
        mv_pos = pos + 3'd1;
        mv_dir = (pos == 3'd6);
      end
    end else begin
      if (pos == 3'd0) begin
        mv_pos = 3'd1;
        mv_dir = 1'b0;
      end else begin
        mv_pos = pos - 3'd1;
        mv_dir = (pos != 3'd1);
      end
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    step_n  = step_cnt;
    flash_n = flash_cnt;
    blink_n = blink;
    score_n = score;
    lives_n = lives;
    level_n = level;
    if (enable) begin
      unique case (state)
        S_IDLE, S_OVER, S_WIN: begin
          if (btn_start) begin
            state_n = S_RUN;
            pos_n   = 3'd0;
            dir_n   = 1'b0;
            step_n  = 2'd0;
            score_n = 4'd0;
            lives_n = 2'(LIVES);
            level_n = 2'd0;
          end else if (tick && state != S_IDLE) begin
            blink_n = ~blink;
          end
        end
        S_RUN: begin
          if (btn_hit) begin
            flash_n = 4'd0;
            if (pos == 3'(TARGET)) begin
              state_n = S_HIT;
              score_n = (score == 4'd15) ? 4'd15 : score + 4'd1;
              if ((int'(score_n) % LEVEL_STEP) == 0 && level != 2'd3)
                level_n = level + 2'd1;
            end else begin
              state_n = S_MISS;
              lives_n = lives - 2'd1;
            end
          end else if (tick) begin
            if (step_cnt == 2'd3 - level) begin
              step_n = 2'd0;
              pos_n  = mv_pos;
              dir_n  = mv_dir;
            end else begin
              step_n = step_cnt + 2'd1;
            end
          end
        end
        S_HIT, S_MISS: begin
          if (tick) begin
            if (flash_cnt == 4'(FLASH_TICKS - 1)) begin
              flash_n = 4'd0;
              blink_n = 1'b0;
              pos_n   = 3'd0;
              dir_n   = 1'b0;
              step_n  = 2'd0;
              if (state == S_HIT)
                state_n = (int'(score) >= WIN_SCORE) ? S_WIN : S_RUN;
              else
                state_n = (lives == 2'd0) ? S_OVER : S_RUN;
            end else begin
              flash_n = flash_cnt + 4'd1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // LEDs follow the next state so they update with the same edge
  always_comb begin
    red_n   = 8'h00;
    green_n = 8'h00;
    unique case (state_n)
      S_RUN:   red_n   = 8'h01 << pos_n;
      S_HIT:   green_n = 8'hFF;
      S_MISS:  red_n   = 8'hFF;
      S_OVER:  red_n   = blink_n ? 8'h55 : 8'hAA;
      S_WIN:   green_n = blink_n ? 8'hAA : 8'h55;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pos        <= 3'd0;
      dir        <= 1'b0;
      step_cnt   <= 2'd0;
      flash_cnt  <= 4'd0;
      blink      <= 1'b0;
      score      <= 4'd0;
      lives      <= 2'(LIVES);
      level      <= 2'd0;
      leds_red   <= 8'h00;
      leds_green <= 8'h00;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      dir        <= dir_n;
      step_cnt   <= step_n;
      flash_cnt  <= flash_n;
      blink      <= blink_n;
      score      <= score_n;
      lives      <= lives_n;
      level      <= level_n;
      leds_red   <= red_n;
      leds_green <= green_n;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_lights_game_ctrl.sv
// Scoreboard bench for lights_game_ctrl: stimulus pushes expected snapshots,
// a monitor pops and compares them after each clock edge or reset event.
module tb_lights_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_hit = 1'b0;
  logic       modo = 1'b1;
  logic [7:0] leds_red, leds_green;
  logic [3:0] score;
  logic [1:0] lives, level;
  logic [2:0] game_state;

  lights_game_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .btn_start(btn_start), .btn_hit(btn_hit), .modo(modo),
    .leds_red(leds_red), .leds_green(leds_green), .score(score),
    .lives(lives), .level(level), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] r;
    logic [7:0] g;
    logic [3:0] sc;
    logic [1:0] lv;
    logic [1:0] lvl;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic cmp(string tag, string f, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", tag, f, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.tag, "state", int'(game_state), int'(e.st));
        cmp(e.tag, "red", int'(leds_red), int'(e.r));
        cmp(e.tag, "green", int'(leds_green), int'(e.g));
        cmp(e.tag, "score", int'(score), int'(e.sc));
        cmp(e.tag, "lives", int'(lives), int'(e.lv));
        cmp(e.tag, "level", int'(level), int'(e.lvl));
      end
    end
  end

  task automatic drive(input logic t, input logic s, input logic h);
    @(negedge clk);
    tick = t;
    btn_start = s;
    btn_hit = h;
  endtask

  task automatic expect_o(string tag, logic [2:0] st, logic [7:0] r,
                          logic [7:0] g, logic [3:0] sc, logic [1:0] lv,
                          logic [1:0] lvl);
    exp_t e;
    e.tag = tag; e.st = st; e.r = r; e.g = g;
    e.sc = sc; e.lv = lv; e.lvl = lvl;
    q.push_back(e);
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chk(string tag, logic [2:0] st, logic [7:0] r,
                     logic [7:0] g, logic [3:0] sc, logic [1:0] lv,
                     logic [1:0] lvl);
    drive(1'b0, 1'b0, 1'b0);
    expect_o(tag, st, r, g, sc, lv, lvl);
  endtask

  initial begin
    int sc_m;
    int lvl_m;
    #2 reset = 1'b0;
    chk("reset", 3'd0, 8'h00, 8'h00, 4'd0, 2'd3, 2'd0);
    @(negedge clk) reset = 1'b1;
    chk("idle", 3'd0, 8'h00, 8'h00, 4'd0, 2'd3, 2'd0);

    drive(1'b0, 1'b1, 1'b0);
    expect_o("start", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);

    ticks(3);
    chk("wrap3", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);
    ticks(1);
    chk("wrap4", 3'd1, 8'h02, 8'h00, 4'd0, 2'd3, 2'd0);
    ticks(12);
    chk("wrap16", 3'd1, 8'h10, 8'h00, 4'd0, 2'd3, 2'd0);
    ticks(16);
    chk("wrap32", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);

    modo = 1'b0;
    ticks(28);
    chk("bnc28", 3'd1, 8'h80, 8'h00, 4'd0, 2'd3, 2'd0);
    ticks(4);
    chk("bnc32", 3'd1, 8'h40, 8'h00, 4'd0, 2'd3, 2'd0);
    ticks(8);
    chk("bnc40", 3'd1, 8'h10, 8'h00, 4'd0, 2'd3, 2'd0);

    drive(1'b1, 1'b0, 1'b1);
    expect_o("hit1", 3'd2, 8'h00, 8'hFF, 4'd1, 2'd3, 2'd0);
    ticks(3);
    chk("flash3", 3'd2, 8'h00, 8'hFF, 4'd1, 2'd3, 2'd0);
    ticks(1);
    chk("ret1", 3'd1, 8'h01, 8'h00, 4'd1, 2'd3, 2'd0);

    ticks(16);
    chk("pos4b", 3'd1, 8'h10, 8'h00, 4'd1, 2'd3, 2'd0);
    drive(1'b1, 1'b0, 1'b1);
    expect_o("hit2", 3'd2, 8'h00, 8'hFF, 4'd2, 2'd3, 2'd1);
    ticks(4);
    chk("ret2", 3'd1, 8'h01, 8'h00, 4'd2, 2'd3, 2'd1);
    ticks(2);
    chk("lvl1_2t", 3'd1, 8'h01, 8'h00, 4'd2, 2'd3, 2'd1);
    ticks(1);
    chk("lvl1_3t", 3'd1, 8'h02, 8'h00, 4'd2, 2'd3, 2'd1);

    drive(1'b0, 1'b0, 1'b1);
    expect_o("miss1", 3'd3, 8'hFF, 8'h00, 4'd2, 2'd2, 2'd1);
    ticks(3);
    chk("mflash", 3'd3, 8'hFF, 8'h00, 4'd2, 2'd2, 2'd1);
    ticks(1);
    chk("mret1", 3'd1, 8'h01, 8'h00, 4'd2, 2'd2, 2'd1);
    drive(1'b0, 1'b1, 1'b1);
    expect_o("miss2", 3'd3, 8'hFF, 8'h00, 4'd2, 2'd1, 2'd1);
    ticks(4);
    chk("mret2", 3'd1, 8'h01, 8'h00, 4'd2, 2'd1, 2'd1);
    drive(1'b0, 1'b0, 1'b1);
    expect_o("miss3", 3'd3, 8'hFF, 8'h00, 4'd2, 2'd0, 2'd1);
    ticks(4);
    chk("over", 3'd4, 8'hAA, 8'h00, 4'd2, 2'd0, 2'd1);
    ticks(1);
    chk("over_t1", 3'd4, 8'h55, 8'h00, 4'd2, 2'd0, 2'd1);
    ticks(1);
    chk("over_t2", 3'd4, 8'hAA, 8'h00, 4'd2, 2'd0, 2'd1);
    drive(1'b0, 1'b1, 1'b1);
    expect_o("restart", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);

    @(negedge clk) enable = 1'b0;
    repeat (20) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1);
    chk("frozen", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);
    @(negedge clk) enable = 1'b1;
    ticks(16);
    chk("unfrz", 3'd1, 8'h10, 8'h00, 4'd0, 2'd3, 2'd0);
    drive(1'b1, 1'b0, 1'b1);
    expect_o("hit3", 3'd2, 8'h00, 8'hFF, 4'd1, 2'd3, 2'd0);
    @(negedge clk);
    tick = 1'b0; btn_hit = 1'b0;
    #2 reset = 1'b0;
    expect_o("arst", 3'd0, 8'h00, 8'h00, 4'd0, 2'd3, 2'd0);
    -> chk_ev;
    @(negedge clk) reset = 1'b1;
    chk("arst_idle", 3'd0, 8'h00, 8'h00, 4'd0, 2'd3, 2'd0);

    drive(1'b0, 1'b1, 1'b0);
    expect_o("start2", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);
    sc_m = 0;
    lvl_m = 0;
    for (int k = 1; k <= 8; k++) begin
      ticks(4 * (4 - lvl_m));
      drive(1'b1, 1'b0, 1'b1);
      sc_m = k;
      if (sc_m % 2 == 0 && lvl_m < 3) lvl_m++;
      expect_o("whit", 3'd2, 8'h00, 8'hFF, 4'(sc_m), 2'd3, 2'(lvl_m));
      ticks(4);
      if (k < 8)
        chk("wret", 3'd1, 8'h01, 8'h00, 4'(sc_m), 2'd3, 2'(lvl_m));
      else
        chk("win", 3'd5, 8'h00, 8'h55, 4'd8, 2'd3, 2'd3);
    end
    ticks(1);
    chk("win_t1", 3'd5, 8'h00, 8'hAA, 4'd8, 2'd3, 2'd3);
    drive(1'b0, 1'b1, 1'b1);
    expect_o("win_rst", 3'd1, 8'h01, 8'h00, 4'd0, 2'd3, 2'd0);
    drive(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue: %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
